// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, receiver state encoding and default sizing.
package uart_pkg;

    localparam int OVERSAMPLE_DEF = 16;
    localparam int DATA_WIDTH_DEF = 8;

    localparam logic [1:0] PARITY_NONE     = 2'b00;
    localparam logic [1:0] PARITY_ODD      = 2'b01;
    localparam logic [1:0] PARITY_EVEN     = 2'b10;
    localparam logic [1:0] PARITY_NONE_ALT = 2'b11;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

    function automatic logic parity_enabled(input logic [1:0] ptype);
        return (ptype == PARITY_ODD) || (ptype == PARITY_EVEN);
    endfunction

endpackage

// File: rtl/uart_rx_sipo_if.sv
// Receiver-facing UART bundle: serial line and parity select in, received byte and status out.
interface uart_rx_sipo_if import uart_pkg::*; #(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
    logic                  data_rx;
    logic [1:0]            parity_type;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  active_flag;
    logic                  done_flag;
    logic                  parity_error;
    logic                  stop_error;

    modport master (
        output data_rx, parity_type,
        input  rx_data, active_flag, done_flag, parity_error, stop_error
    );

    modport slave (
        input  data_rx, parity_type,
        output rx_data, active_flag, done_flag, parity_error, stop_error
    );
endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for bringing the asynchronous serial line into the baud clock domain.
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;
endmodule

// File: rtl/uart_rx_sipo.sv
// UART receive SIPO: qualifies the start bit, samples each bit at mid-bit, checks parity and stop.
module uart_rx_sipo import uart_pkg::*; #(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic           baud_clk,
    input  logic           reset,
    uart_rx_sipo_if.slave  bus
);
    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_WIDTH + 1);
    localparam logic [TICK_W-1:0] MID_TICK = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] BIT_TICK = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(DATA_WIDTH - 1);

    logic rx_s;

    rx_state_e             state_q, state_d;
    logic [TICK_W-1:0]     tick_q, tick_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [1:0]            ptype_q, ptype_d;
    logic                  par_pend_q, par_pend_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  active_q, active_d;
    logic                  done_q, done_d;
    logic                  perr_q, perr_d;
    logic                  serr_q, serr_d;

    uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk   (baud_clk),
        .reset (reset),
        .d     (bus.data_rx),
        .q     (rx_s)
    );

    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        ptype_d    = ptype_q;
        par_pend_d = par_pend_q;
        rx_data_d  = rx_data_q;
        active_d   = active_q;
        done_d     = 1'b0;
        perr_d     = perr_q;
        serr_d     = serr_q;

        unique case (state_q)
            RX_IDLE: begin
                if (!rx_s) begin
                    state_d  = RX_START;
                    tick_d   = '0;
                    ptype_d  = bus.parity_type;
                    active_d = 1'b1;
                end
            end
            RX_START: begin
                tick_d = tick_q + TICK_W'(1);
                if (tick_q == MID_TICK) begin
                    tick_d = '0;
                    if (!rx_s) begin
                        state_d = RX_DATA;
                        bit_d   = '0;
                    end else begin
                        state_d  = RX_IDLE;
                        active_d = 1'b0;
                    end
                end
            end
            RX_DATA: begin
                tick_d = tick_q + TICK_W'(1);
                if (tick_q == BIT_TICK) begin
                    tick_d     = '0;
                    shift_d    = {rx_s, shift_q[DATA_WIDTH-1:1]};
                    bit_d      = bit_q + BIT_W'(1);
                    if (bit_q == LAST_BIT) begin
                        par_pend_d = 1'b0;
                        state_d    = parity_enabled(ptype_q) ? RX_PARITY : RX_STOP;
                    end
                end
            end
            RX_PARITY: begin
                tick_d = tick_q + TICK_W'(1);
                if (tick_q == BIT_TICK) begin
                    tick_d  = '0;
                    state_d = RX_STOP;
                    // Odd parity expects the inverted XOR so the total count of ones is odd.
                    if (ptype_q == PARITY_ODD) begin
                        par_pend_d = (rx_s != ~^shift_q);
                    end else begin
                        par_pend_d = (rx_s != ^shift_q);
                    end
                end
            end
            RX_STOP: begin
                tick_d = tick_q + TICK_W'(1);
                // Leaving at mid stop bit lets a following start bit be caught without an idle gap.
                if (tick_q == BIT_TICK) begin
                    tick_d    = '0;
                    state_d   = RX_IDLE;
                    done_d    = 1'b1;
                    rx_data_d = shift_q;
                    perr_d    = par_pend_q;
                    serr_d    = ~rx_s;
                    active_d  = 1'b0;
                end
            end
            default: begin
                state_d  = RX_IDLE;
                active_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge baud_clk or posedge reset) begin
        if (reset) begin
            state_q    <= RX_IDLE;
            tick_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            ptype_q    <= PARITY_NONE;
            par_pend_q <= 1'b0;
            rx_data_q  <= '0;
            active_q   <= 1'b0;
            done_q     <= 1'b0;
            perr_q     <= 1'b0;
            serr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            ptype_q    <= ptype_d;
            par_pend_q <= par_pend_d;
            rx_data_q  <= rx_data_d;
            active_q   <= active_d;
            done_q     <= done_d;
            perr_q     <= perr_d;
            serr_q     <= serr_d;
        end
    end

    assign bus.rx_data      = rx_data_q;
    assign bus.active_flag  = active_q;
    assign bus.done_flag    = done_q;
    assign bus.parity_error = perr_q;
    assign bus.stop_error   = serr_q;
endmodule

// File: tb/tb_uart_rx_sipo.sv
// Directed bench for uart_rx_sipo: table of whole frames plus hand-built glitch, back-to-back and reset cases.
module tb_uart_rx_sipo;
    localparam int OS = 16;
    // Two synchronizer stages sit between the driven line and the FSM's view of it.
    localparam int LAT_NOPAR = 9 * OS + OS / 2 + 1 + 2;
    localparam int LAT_PAR   = 10 * OS + OS / 2 + 1 + 2;

    logic baud_clk;
    logic reset;
    int   cyc;
    int   checks;
    int   errors;

    uart_rx_sipo_if #(.DATA_WIDTH(8)) bus ();

    uart_rx_sipo #(.OVERSAMPLE(OS), .DATA_WIDTH(8)) dut (
        .baud_clk (baud_clk),
        .reset    (reset),
        .bus      (bus)
    );

    typedef struct {
        int         cyc;
        logic [7:0] data;
        logic       perr;
        logic       serr;
    } done_rec_t;

    typedef struct {
        logic [7:0] data;
        logic [1:0] ptype;
        logic       par_bit;
        logic       stop_bit;
        logic [7:0] exp_data;
        logic       exp_perr;
        logic       exp_serr;
        int         exp_lat;
    } vec_t;

    done_rec_t dq[$];
    vec_t      vecs[6];

    initial baud_clk = 1'b0;
    always #5 baud_clk = ~baud_clk;

    always @(posedge baud_clk) cyc <= cyc + 1;

    // Log every cycle in which done_flag is seen high, sampled well after the edge.
    always begin
        @(posedge baud_clk);
        #2;
        if (bus.done_flag === 1'b1) begin
            dq.push_back('{cyc: cyc, data: bus.rx_data, perr: bus.parity_error, serr: bus.stop_error});
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        bus.data_rx = b;
        repeat (OS) @(posedge baud_clk);
        #1;
    endtask

    // Drives start, data LSB-first, optional parity and stop; parity_type is disturbed after the start bit.
    task automatic apply_stimulus(input logic [7:0] data, input logic [1:0] ptype, input logic par_bit,
                                  input logic stop_bit, output int start_cyc);
        bus.parity_type = ptype;
        start_cyc = cyc;
        send_bit(1'b0);
        bus.parity_type = ptype ^ 2'b01;
        for (int i = 0; i < 8; i++) send_bit(data[i]);
        if (ptype == 2'b01 || ptype == 2'b10) send_bit(par_bit);
        send_bit(stop_bit);
    endtask

    task automatic get_rec(input int idx, output done_rec_t rec);
        if (dq.size() > idx) rec = dq[idx];
        else rec = '{cyc: -1, data: 8'h00, perr: 1'b0, serr: 1'b0};
    endtask

    initial begin
        int        n0;
        int        s0;
        int        s1;
        int        act_cnt;
        done_rec_t rec;

        cyc = 0;
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus.data_rx = 1'b1;
        bus.parity_type = 2'b00;
        repeat (3) @(posedge baud_clk);
        #1;
        check_output("reset_rx_data", 32'(bus.rx_data), 32'h0);
        check_output("reset_active", 32'(bus.active_flag), 32'h0);
        check_output("reset_done", 32'(bus.done_flag), 32'h0);
        check_output("reset_perr", 32'(bus.parity_error), 32'h0);
        check_output("reset_serr", 32'(bus.stop_error), 32'h0);
        reset = 1'b0;
        repeat (5) @(posedge baud_clk);
        #1;

        // 8'h4A has three ones: odd parity wants 0, even parity wants 1.
        vecs[0] = '{8'h4A, 2'b00, 1'b0, 1'b1, 8'h4A, 1'b0, 1'b0, LAT_NOPAR};
        vecs[1] = '{8'h4A, 2'b01, 1'b0, 1'b1, 8'h4A, 1'b0, 1'b0, LAT_PAR};
        vecs[2] = '{8'h4A, 2'b10, 1'b1, 1'b1, 8'h4A, 1'b0, 1'b0, LAT_PAR};
        vecs[3] = '{8'h4A, 2'b10, 1'b0, 1'b1, 8'h4A, 1'b1, 1'b0, LAT_PAR};
        vecs[4] = '{8'hC3, 2'b01, 1'b0, 1'b1, 8'hC3, 1'b1, 1'b0, LAT_PAR};
        vecs[5] = '{8'h5A, 2'b00, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, LAT_NOPAR};

        for (int i = 0; i < 6; i++) begin
            n0 = dq.size();
            apply_stimulus(vecs[i].data, vecs[i].ptype, vecs[i].par_bit, vecs[i].stop_bit, s0);
            bus.data_rx = 1'b1;
            repeat (40) @(posedge baud_clk);
            #1;
            get_rec(n0, rec);
            check_output($sformatf("vec%0d_done_count", i), 32'(dq.size() - n0), 32'd1);
            check_output($sformatf("vec%0d_latency", i), 32'(rec.cyc - s0), 32'(vecs[i].exp_lat));
            check_output($sformatf("vec%0d_rx_data", i), 32'(rec.data), 32'(vecs[i].exp_data));
            check_output($sformatf("vec%0d_perr", i), 32'(rec.perr), 32'(vecs[i].exp_perr));
            check_output($sformatf("vec%0d_serr", i), 32'(rec.serr), 32'(vecs[i].exp_serr));
        end

        // Short low glitch: must be rejected at the mid-start qualification point.
        n0 = dq.size();
        act_cnt = 0;
        bus.data_rx = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge baud_clk);
            #1;
            if (i == 3) bus.data_rx = 1'b1;
            if (bus.active_flag === 1'b1) act_cnt++;
        end
        check_output("glitch_active_seen", 32'(act_cnt > 0), 32'd1);
        check_output("glitch_active_short", 32'(act_cnt <= OS / 2), 32'd1);
        check_output("glitch_no_done", 32'(dq.size() - n0), 32'd0);
        check_output("glitch_rx_hold", 32'(bus.rx_data), 32'h5A);
        check_output("glitch_serr_hold", 32'(bus.stop_error), 32'h1);
        check_output("glitch_perr_hold", 32'(bus.parity_error), 32'h0);

        // Two frames with no idle between them.
        n0 = dq.size();
        apply_stimulus(8'hA5, 2'b00, 1'b0, 1'b1, s0);
        apply_stimulus(8'h3C, 2'b00, 1'b0, 1'b1, s1);
        bus.data_rx = 1'b1;
        repeat (20) @(posedge baud_clk);
        #1;
        check_output("b2b_done_count", 32'(dq.size() - n0), 32'd2);
        get_rec(n0, rec);
        check_output("b2b_first_data", 32'(rec.data), 32'hA5);
        check_output("b2b_first_latency", 32'(rec.cyc - s0), 32'(LAT_NOPAR));
        get_rec(n0 + 1, rec);
        check_output("b2b_second_data", 32'(rec.data), 32'h3C);
        check_output("b2b_second_latency", 32'(rec.cyc - s1), 32'(LAT_NOPAR));
        check_output("b2b_second_serr", 32'(rec.serr), 32'h0);

        // Reset in the middle of a frame after four data bits.
        n0 = dq.size();
        bus.parity_type = 2'b00;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(i[0]);
        check_output("midreset_active_before", 32'(bus.active_flag), 32'h1);
        reset = 1'b1;
        #1;
        check_output("midreset_rx_data", 32'(bus.rx_data), 32'h0);
        check_output("midreset_active", 32'(bus.active_flag), 32'h0);
        check_output("midreset_done", 32'(bus.done_flag), 32'h0);
        bus.data_rx = 1'b1;
        repeat (3) @(posedge baud_clk);
        #1;
        reset = 1'b0;
        repeat (40) @(posedge baud_clk);
        #1;
        check_output("midreset_no_done", 32'(dq.size() - n0), 32'd0);

        n0 = dq.size();
        apply_stimulus(8'hFF, 2'b00, 1'b0, 1'b1, s0);
        bus.data_rx = 1'b1;
        repeat (20) @(posedge baud_clk);
        #1;
        get_rec(n0, rec);
        check_output("after_reset_done_count", 32'(dq.size() - n0), 32'd1);
        check_output("after_reset_data", 32'(rec.data), 32'hFF);
        check_output("after_reset_latency", 32'(rec.cyc - s0), 32'(LAT_NOPAR));
        check_output("after_reset_perr", 32'(rec.perr), 32'h0);
        check_output("after_reset_serr", 32'(rec.serr), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
